// File: rtl/rs_enc.sv
// ---------------------------------------------------------------------------
// rs_enc -- systematic Reed-Solomon RS(N, N-NPAR) encoder over GF(2^8).
//
// Data symbols are passed straight through (one register stage) while a
// generator-polynomial LFSR accumulates the remainder.  After the last data
// symbol the NPAR remainder symbols are shifted out, highest degree first,
// which is the symbol order the downstream rsdec decoder expects on x.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (discards any partial frame)
//   x          data symbol in
//   in_valid   x valid this cycle
//   in_ready   encoder can take x (low while parity is being emitted)
//   y          codeword symbol out
//   out_valid  y valid
//   out_first  y is codeword symbol 0
//   out_last   y is the final parity symbol
//
// Optional build macro RS_ENC_ERR_INJECT_EN adds inj_en / inj_pos / inj_val:
// a single output symbol of the frame can be XOR-corrupted so decoder
// benches get a known error without a separate corrupter.  The LFSR always
// sees the clean data, so the corruption is a genuine channel-style error.
// ---------------------------------------------------------------------------
module rs_enc #(
    parameter int         N    = 255,
    parameter int         NPAR = 32,
    parameter int         FCR  = 0,
    parameter logic [8:0] PRIM = 9'h11D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x,
    input  logic       in_valid,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic       inj_en,
    input  logic [7:0] inj_pos,
    input  logic [7:0] inj_val,
`endif
    output logic       in_ready,
    output logic [7:0] y,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last
);

    localparam int         K      = N - NPAR;
    localparam logic [7:0] K_LAST = 8'(K - 1);
    localparam logic [7:0] P_LAST = 8'(NPAR - 1);

    // GF(2^8) multiply, shift-and-add with reduction by PRIM.  With one
    // operand constant this collapses to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ PRIM[7:0]) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow_alpha(input int e);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < e; i++) v = gf_mul(v, 8'h02);
        return v;
    endfunction

    // g(x) = prod (x + alpha^(FCR+i)); coefficient j lives in bits [8j +: 8].
    // The leading coefficient is 1 and is not returned.
    function automatic logic [NPAR*8-1:0] gen_poly();
        logic [(NPAR+1)*8-1:0] g;
        logic [7:0]            root;
        g      = '0;
        g[7:0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            root = gf_pow_alpha(FCR + i);
            // Descending j so g[j-1] is still the old coefficient.
            for (int j = NPAR; j > 0; j--)
                g[j*8 +: 8] = g[(j-1)*8 +: 8] ^ gf_mul(g[j*8 +: 8], root);
            g[7:0] = gf_mul(g[7:0], root);
        end
        return g[NPAR*8-1:0];
    endfunction

    localparam logic [NPAR*8-1:0] GEN = gen_poly();

    typedef enum logic {S_DATA, S_PARITY} state_t;

    state_t                 state;
    logic [7:0]             count;
    logic [NPAR-1:0][7:0]   r;
    logic [7:0]             fb;
    logic [7:0]             inj_mask;

    assign fb       = x ^ r[NPAR-1];
    assign in_ready = (state == S_DATA);

`ifdef RS_ENC_ERR_INJECT_EN
    logic       inj_en_q;
    logic [7:0] inj_pos_q;
    logic [7:0] inj_val_q;
    logic [7:0] out_idx;
    logic       first_acc;

    // Codeword index of the symbol being registered this cycle.
    assign out_idx   = (state == S_DATA) ? count : count + 8'(K);
    assign first_acc = (state == S_DATA) && in_valid && (count == 8'd0);

    // Symbol 0 is produced on the same edge that captures the settings, so
    // it must look at the live inputs rather than the held copies.
    always_comb begin
        inj_mask = 8'h00;
        if (first_acc) begin
            if (inj_en && inj_pos == 8'd0) inj_mask = inj_val;
        end else if (inj_en_q && inj_pos_q == out_idx) begin
            inj_mask = inj_val_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= 8'h00;
            inj_val_q <= 8'h00;
        end else if (first_acc) begin
            inj_en_q  <= inj_en;
            inj_pos_q <= inj_pos;
            inj_val_q <= inj_val;
        end
    end
`else
    assign inj_mask = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DATA;
            count     <= 8'h00;
            r         <= '0;
            y         <= 8'h00;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_DATA: begin
                    out_last <= 1'b0;
                    if (in_valid) begin
                        y         <= x ^ inj_mask;
                        out_valid <= 1'b1;
                        out_first <= (count == 8'd0);
                        r[0]      <= gf_mul(fb, GEN[7:0]);
                        for (int i = 1; i < NPAR; i++)
                            r[i] <= r[i-1] ^ gf_mul(fb, GEN[i*8 +: 8]);
                        if (count == K_LAST) begin
                            state <= S_PARITY;
                            count <= 8'h00;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                    end
                end
                S_PARITY: begin
                    y         <= r[NPAR-1] ^ inj_mask;
                    out_valid <= 1'b1;
                    out_first <= 1'b0;
                    for (int i = NPAR - 1; i > 0; i--) r[i] <= r[i-1];
                    r[0] <= 8'h00;
                    if (count == P_LAST) begin
                        out_last <= 1'b1;
                        state    <= S_DATA;
                        count    <= 8'h00;
                    end else begin
                        out_last <= 1'b0;
                        count    <= count + 8'd1;
                    end
                end
                default: state <= S_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_enc.sv
module tb_rs_enc;
    localparam int         N    = 255;
    localparam int         NPAR = 32;
    localparam int         FCR  = 0;
    localparam int         K    = N - NPAR;
    localparam int         NV   = 10;
    localparam int         PRIM = 'h11D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] y;
    logic       out_valid, out_first, out_last;
`ifdef RS_ENC_ERR_INJECT_EN
    logic       inj_en = 1'b0;
    logic [7:0] inj_pos = 8'h00;
    logic [7:0] inj_val = 8'h00;
`endif

    always #5 clk = ~clk;

    rs_enc #(.N(N), .NPAR(NPAR), .FCR(FCR), .PRIM(9'h11D)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid),
`ifdef RS_ENC_ERR_INJECT_EN
        .inj_en(inj_en), .inj_pos(inj_pos), .inj_val(inj_val),
`endif
        .in_ready(in_ready), .y(y), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (log/antilog tables) ----------------
    int         gexp [0:255];
    int         glog [0:255];
    logic [7:0] g    [0:NPAR];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[(glog[a] + glog[b]) % 255]);
    endfunction

    task automatic build_field();
        int e;
        logic [7:0] ng [0:NPAR];
        logic [7:0] root;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = e;
            glog[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e = e ^ PRIM;
        end
        for (int j = 0; j <= NPAR; j++) g[j] = 8'h00;
        g[0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            root = 8'(gexp[(FCR + i) % 255]);
            for (int j = 0; j <= NPAR; j++)
                ng[j] = ((j > 0) ? g[j-1] : 8'h00) ^ gm(g[j], root);
            for (int j = 0; j <= NPAR; j++) g[j] = ng[j];
        end
    endtask

    logic [7:0] vdata [NV][K];
    logic [7:0] vcw   [NV][N];
    logic [7:0] rx    [N];

    // Codeword = m(x)*x^NPAR + (m(x)*x^NPAR mod g(x)), by long division.
    task automatic make_cw(input int v);
        logic [7:0] p [0:N-1];
        logic [7:0] c;
        for (int d = 0; d < N; d++) p[d] = 8'h00;
        for (int k = 0; k < K; k++) p[N-1-k] = vdata[v][k];
        for (int d = N - 1; d >= NPAR; d--) begin
            c = p[d];
            for (int j = 0; j <= NPAR; j++) p[d-NPAR+j] ^= gm(c, g[j]);
        end
        for (int k = 0; k < K; k++) vcw[v][k] = vdata[v][k];
        for (int m = 0; m < NPAR; m++) vcw[v][K+m] = p[NPAR-1-m];
    endtask

    // Received word evaluated at alpha^(FCR+i); rx[0] is the highest degree.
    function automatic logic [7:0] syn(input int i);
        logic [7:0] s, a;
        s = 8'h00;
        a = 8'(gexp[(FCR + i) % 255]);
        for (int k = 0; k < N; k++) s = gm(s, a) ^ rx[k];
        return s;
    endfunction

    // ---------------- output monitor ----------------
    typedef struct packed { logic [7:0] y; logic f; logic l; } obs_t;
    obs_t q[$];
    int   first_cycs[$];
    int   last_cycs[$];
    int   cyc = 0;
    int   ready_low = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (!in_ready) ready_low++;
            if (out_valid) begin
                q.push_back('{y: y, f: out_first, l: out_last});
                if (out_first) first_cycs.push_back(cyc);
                if (out_last)  last_cycs.push_back(cyc);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic put_sym(input logic [7:0] v, input int gap_pct);
        int guard;
        for (int gcount = 0; gcount < 2; gcount++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            in_valid = 1'b0;
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        x = v;
        in_valid = 1'b1;
    endtask

    task automatic send_frame(input int v, input int gap_pct);
        for (int k = 0; k < K; k++) put_sym(vdata[v][k], gap_pct);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int cnt);
        int c;
        c = 0;
        while (q.size() < cnt && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (q.size() < cnt) begin
            n_cmp++; n_bad++;
            $display("FAIL out_timeout: got %0d symbols, required %0d", q.size(), cnt);
        end
    endtask

    // Pop one codeword and compare symbol + first/last flags; optional
    // expected single-symbol corruption at fpos. Then check syndromes.
    task automatic check_cw(input int v, input string nm, input int fpos, input logic [7:0] fval);
        obs_t       o;
        logic [7:0] e;
        logic       any_nz;
        for (int i = 0; i < N; i++) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_short: got %0d symbols, required %0d", nm, i, N);
                return;
            end
            o = q.pop_front();
            rx[i] = o.y;
            e = vcw[v][i] ^ ((i == fpos) ? fval : 8'h00);
            chk($sformatf("%s[%0d]{y,first,last}", nm, i), {22'd0, o.y, o.f, o.l},
                {22'd0, e, (i == 0), (i == N - 1)});
        end
        if (fval == 8'h00) begin
            for (int i = 0; i < NPAR; i++) chk($sformatf("%s_syn%0d", nm, i), syn(i), 0);
        end else begin
            any_nz = 1'b0;
            for (int i = 0; i < NPAR; i++) if (syn(i) != 8'h00) any_nz = 1'b1;
            chk($sformatf("%s_syn_nonzero", nm), any_nz, 1);
            // Single error e at degree d: S0 = e, S1 = e*alpha^d (FCR = 0).
            chk($sformatf("%s_err_mag", nm), syn(0), fval);
            chk($sformatf("%s_err_loc", nm), syn(1), gm(fval, 8'(gexp[(N - 1 - fpos) % 255])));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    kind;          // 0 zeros, 1 impulse, 2 random
        int    gap_pct;
        int    exp_cw;        // codeword the outputs must equal
        int    exp_ready_low; // cycles in_ready is low for the frame
    } vec_t;
    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        build_field();
        for (int v = 0; v < NV; v++)
            for (int k = 0; k < K; k++) vdata[v][k] = 8'($urandom_range(255));
        for (int k = 0; k < K; k++) vdata[0][k] = 8'h00;
        for (int k = 0; k < K; k++) vdata[1][k] = (k == K - 1) ? 8'h01 : 8'h00;
        for (int k = 0; k < K; k++) vdata[3][k] = vdata[2][k];
        for (int v = 0; v < NV; v++) make_cw(v);

        vt[0] = '{name: "zero",     kind: 0, gap_pct: 0,  exp_cw: 0, exp_ready_low: NPAR};
        vt[1] = '{name: "impulse",  kind: 1, gap_pct: 0,  exp_cw: 1, exp_ready_low: NPAR};
        vt[2] = '{name: "rand",     kind: 2, gap_pct: 0,  exp_cw: 2, exp_ready_low: NPAR};
        vt[3] = '{name: "rand_gap", kind: 2, gap_pct: 35, exp_cw: 2, exp_ready_low: NPAR};
        vt[4] = '{name: "rand_g2",  kind: 2, gap_pct: 15, exp_cw: 4, exp_ready_low: NPAR};

        // Reset state.
        #1;
        chk("rst_y", y, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            ready_low = 0;
            send_frame(t == 3 ? 2 : t, vt[t].gap_pct);
            idle();
            wait_q(N);
            check_cw(vt[t].exp_cw, vt[t].name, -1, 8'h00);
            chk({vt[t].name, "_ready_low"}, ready_low, vt[t].exp_ready_low);
            if (vt[t].kind == 1)
                for (int m = 0; m < NPAR; m++)
                    chk($sformatf("impulse_gen%0d", NPAR - 1 - m), rx[K+m], g[NPAR-1-m]);
        end

        // Back-to-back frames.
        q.delete(); first_cycs.delete(); last_cycs.delete();
        send_frame(5, 0);
        send_frame(6, 0);
        idle();
        wait_q(2 * N);
        check_cw(5, "b2b_a", -1, 8'h00);
        check_cw(6, "b2b_b", -1, 8'h00);
        chk("b2b_first_count", first_cycs.size(), 2);
        chk("b2b_last_count", last_cycs.size(), 2);
        if (first_cycs.size() == 2 && last_cycs.size() >= 1)
            chk("b2b_no_idle", first_cycs[1], last_cycs[0] + 1);

        // Async reset in the middle of the data phase.
        for (int k = 0; k < 100; k++) put_sym(vdata[7][k], 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_y", y, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_first", out_first, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete(); first_cycs.delete(); last_cycs.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8, 0);
        idle();
        wait_q(N);
        check_cw(8, "post_rst", -1, 8'h00);

`ifdef RS_ENC_ERR_INJECT_EN
        inj_en = 1'b1; inj_pos = 8'd7; inj_val = 8'h5A;
        send_frame(9, 10);
        inj_en = 1'b0; inj_pos = 8'd0; inj_val = 8'h00;
        idle();
        wait_q(N);
        check_cw(9, "inject", 7, 8'h5A);
        send_frame(9, 0);
        idle();
        wait_q(N);
        check_cw(9, "inject_off", -1, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs_enc.md
Name: rs_enc

Overview:
- Systematic RS(N, N-NPAR) encoder over GF(2^8), primitive polynomial 0x11D.
- Sits directly upstream of rsdec and produces the codeword stream that rsdec consumes.
- Accepts N-NPAR data symbols, passes them through registered, then emits NPAR parity symbols computed by a generator-polynomial LFSR built from gf_mul constant multipliers.
- Output order is highest-degree symbol first, the same order rsdec expects on x.

Parameters:
- N, 255: codeword length in symbols (NPAR+1..255).
- NPAR, 32: parity symbols (2t); must equal the k driven into rsdec.
- FCR, 0: first consecutive root; g(x) = prod_{i=0..NPAR-1} (x - alpha^(FCR+i)); matches rsdec.
- PRIM, 9'h11D: field primitive polynomial.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  8  data symbol.
- in_valid  in  1  x valid this cycle.
- in_ready  out  1  encoder accepts x; low during parity emission.
- y  out  8  codeword symbol.
- out_valid  out  1  y valid.
- out_first  out  1  y is codeword symbol 0 (first data symbol).
- out_last  out  1  y is final parity symbol.

Behaviour:
- Generator coefficients g[0..NPAR-1] (monic, g[NPAR]=1) are computed at elaboration by a constant function; no runtime table load.
- Reset (async, rst_n=0):
  - State DATA; count=0; LFSR r[0..NPAR-1]=0.
  - y=0, out_valid=0, out_first=0, out_last=0, in_ready=1.
  - Reset mid-frame discards the partial frame; the next accepted symbol starts a new frame.
- States: DATA, PARITY.
- DATA:
  - in_ready=1. Accept occurs when in_valid=1.
  - On accept: y<=x, out_valid<=1, out_first<=(count==0), count++.
  - LFSR update on accept: fb=x^r[NPAR-1]; r[0]<=fb*g[0]; r[i]<=r[i-1]^fb*g[i] for i=1..NPAR-1 (GF multiply, XOR add).
  - Cycle with in_valid=0: out_valid<=0, LFSR and count hold. Gaps are allowed anywhere in the data phase.
  - Accept of data symbol N-NPAR-1: next state PARITY, count reset to 0.
- PARITY:
  - in_ready=0; in_valid is ignored.
  - Each cycle: y<=r[NPAR-1], out_valid<=1; r shifts up (r[i]<=r[i-1], r[0]<=0); count++.
  - After NPAR cycles: out_last<=1 with the final parity symbol, next state DATA, r is all zero.
- Latency: one cycle from accept to y for data symbols.
- The first parity symbol appears on the cycle immediately after the last data symbol's output; a frame is contiguous once the data phase completes.
- Back-to-back frames: the next frame's first data symbol may be accepted on the cycle in_ready returns high. No idle cycle is inserted.
- out_first and out_last are single-cycle pulses qualified by out_valid. Both are 0 outside those cycles.
- Width rules: all GF arithmetic is 8-bit, XOR addition. count is 8 bits, wrapping is impossible by construction (max N-1).

Optional Feature:
- Macro: RS_ENC_ERR_INJECT_EN.
- When defined, adds three inputs:
  - inj_en, 1 bit.
  - inj_pos, 8 bits: codeword index 0..N-1, 0 = first output symbol.
  - inj_val, 8 bits.
- All three are sampled on the out_first cycle and held for the frame.
- When sampled inj_en=1, the output symbol at index inj_pos is XORed with inj_val; the LFSR still uses the uncorrupted x.
- Lets rsdec benches exercise with_error/error without a separate corrupter.
- When undefined: ports absent, output is always the clean codeword, no added logic.

Test Plan:
1. All-zero frame: 223 zero symbols, in_valid held high -> 255 zero outputs; out_first on output 0; out_last on output 254; in_ready low for exactly 32 cycles.
2. Unit impulse: 222 zeros then 1 -> parity outputs equal g[31], g[30], ..., g[0]; compare against a reference model built from gf_mul.
3. Random 223-symbol frame with random in_valid gaps -> outputs identical to the gap-free run. Feeding the codeword to rsdec with k=32 -> with_error=0. The bench also checks all 32 syndromes are zero.
4. Back-to-back frames: two random frames with no idle -> second frame's out_first occurs the cycle after the first frame's out_last. Both codewords decode clean.
5. Async reset asserted at data symbol 100 -> all outputs 0 immediately. A fresh full frame afterwards encodes correctly, with no residue from the aborted frame.
6. With RS_ENC_ERR_INJECT_EN: inj_pos=7, inj_val=8'h5A -> only output 7 differs, by 0x5A. rsdec reports with_error=1 and error magnitude 0x5A at that position.
